// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command scheduler: command encodings,
// scheduler state type and a legality helper.
// The optional watchdog is enabled with the SCHED_TIMEOUT_EN macro, which
// adds the S_ERR state to sched_state_t.
package lcd_pkg;

    localparam logic [3:0] CMD_WRITE    = 4'd0;
    localparam logic [3:0] CMD_UP       = 4'd1;
    localparam logic [3:0] CMD_DOWN     = 4'd2;
    localparam logic [3:0] CMD_LEFT     = 4'd3;
    localparam logic [3:0] CMD_RIGHT    = 4'd4;
    localparam logic [3:0] CMD_MAX      = 4'd5;
    localparam logic [3:0] CMD_MIN      = 4'd6;
    localparam logic [3:0] CMD_AVG      = 4'd7;
    localparam logic [3:0] CMD_ROT_CCW  = 4'd8;
    localparam logic [3:0] CMD_ROT_CW   = 4'd9;
    localparam logic [3:0] CMD_MIRROR_X = 4'd10;
    localparam logic [3:0] CMD_MIRROR_Y = 4'd11;
    localparam logic [3:0] CMD_LAST     = 4'd11;

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_IDLE  = 3'd1,
        S_GUARD = 3'd2,
        S_WAIT  = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
`ifdef SCHED_TIMEOUT_EN
        ,
        S_ERR   = 3'd6
`endif
    } sched_state_t;

    // Codes above CMD_LAST have no meaning to the engine.
    function automatic logic cmd_is_legal(input logic [3:0] code);
        return code <= CMD_LAST;
    endfunction

endpackage

// File: rtl/lcd_cmd_sched_if.sv
// Host-side command channel of the LCD command scheduler.
// Handshake: a command transfers in every cycle where host_valid and
// host_ready are both high on the rising clock edge; host_cmd must be
// stable while host_valid is high, and host_ready does not depend on
// host_valid in the same cycle.
interface lcd_cmd_sched_if;

    logic [3:0] host_cmd;
    logic       host_valid;
    logic       host_ready;

    modport master (
        output host_cmd,
        output host_valid,
        input  host_ready
    );

    modport slave (
        input  host_cmd,
        input  host_valid,
        output host_ready
    );

endinterface

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy and full/empty flags.
// Read data is the current head (show-ahead); a push is ignored when full
// and a pop is ignored when empty.
module lcd_cmd_fifo #(
    parameter  int DEPTH = 8,
    parameter  int W     = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q];
    assign level_o = level_q;

    // Pointer and occupancy update; a simultaneous push and pop keeps the level.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage array; contents need no reset since the level gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    // Pointer and level registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/lcd_cmd_sched.sv
// LCD command scheduler: buffers host commands and issues them one at a
// time to the 8x8 image engine, closing each frame with WRITE (cmd 0) and
// waiting for the engine's done pulse before re-arming for the ROM load.
// Optional watchdog: define SCHED_TIMEOUT_EN to enable the TIMEOUT-cycle
// watchdog and the terminal S_ERR state.
module lcd_cmd_sched
    import lcd_pkg::*;
#(
    parameter  int DEPTH   = 8,
    parameter  int CNT_W   = 8,
    parameter  int TIMEOUT = 1024,
    localparam int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    lcd_cmd_sched_if.slave     host,
    input  logic               lcd_busy,
    input  logic               lcd_done,
    output logic [3:0]         lcd_cmd,
    output logic               lcd_cmd_valid,
    output logic [LVL_W-1:0]   fifo_level,
    output logic [CNT_W-1:0]   issued_cnt,
    output logic               illegal_cmd,
    output logic               frame_done,
    output logic               timeout,
    output sched_state_t       state_o
);

    sched_state_t     state_q, state_d;
    logic [3:0]       lcd_cmd_q;
    logic [CNT_W-1:0] issued_cnt_q;
    logic             illegal_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic [3:0]       fifo_head;
    logic [LVL_W-1:0] fifo_lvl;

    logic             enq_fire;
    logic             cmd_legal;
    logic             issue;
    logic             issue_fire;
    logic             in_err;

    assign cmd_legal  = cmd_is_legal(host.host_cmd);
    assign enq_fire   = host.host_valid && host.host_ready;
    assign issue_fire = issue && !reset;

    lcd_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (4)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (enq_fire && cmd_legal),
        .data_i  (host.host_cmd),
        .pop_i   (issue_fire),
        .data_o  (fifo_head),
        .level_o (fifo_lvl),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            timeout_q;
    logic            wd_run;
    logic            wd_expire;

    assign wd_run    = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_FLUSH);
    assign wd_expire = wd_run && (wdog_q == WD_W'(TIMEOUT - 1));
    assign in_err    = (state_q == S_ERR);
    assign timeout   = !reset && timeout_q;

    // Watchdog counts cycles spent in a waiting state, restarting on every state change.
    always_comb begin
        wdog_d = wdog_q;
        if (state_d != state_q) wdog_d = '0;
        else if (wd_run)        wdog_d = wdog_q + WD_W'(1);
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            if (wd_expire) timeout_q <= 1'b1;
        end
    end
`else
    assign in_err  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Next-state and issue decision; an issue only ever happens in S_IDLE.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            S_LOAD:  if (!lcd_busy) state_d = S_IDLE;
            S_IDLE: begin
                if (!fifo_empty && !lcd_busy) begin
                    issue   = 1'b1;
                    state_d = (fifo_head == CMD_WRITE) ? S_FLUSH : S_GUARD;
                end
            end
            // The engine raises busy a cycle late, so busy is not trusted here.
            S_GUARD: state_d = S_WAIT;
            S_WAIT:  if (!lcd_busy) state_d = S_IDLE;
            S_FLUSH: if (lcd_done) state_d = S_DONE;
            S_DONE:  state_d = S_LOAD;
`ifdef SCHED_TIMEOUT_EN
            S_ERR:   state_d = S_ERR;
`endif
            default: state_d = S_LOAD;
        endcase
`ifdef SCHED_TIMEOUT_EN
        if (wd_expire) state_d = S_ERR;
`endif
    end

    // State register, held command, issue counter and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOAD;
            lcd_cmd_q    <= 4'd0;
            issued_cnt_q <= '0;
            illegal_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue_fire) begin
                lcd_cmd_q    <= fifo_head;
                issued_cnt_q <= issued_cnt_q + CNT_W'(1);
            end
            if (enq_fire && !cmd_legal) illegal_q <= 1'b1;
        end
    end

    // Outputs read 0 while reset is held; lcd_cmd shows the head during the
    // strobe and then holds it until the next issue.
    assign host.host_ready = !reset && !fifo_full && !in_err;
    assign lcd_cmd_valid   = issue_fire;
    assign lcd_cmd         = reset ? 4'd0 : (issue_fire ? fifo_head : lcd_cmd_q);
    assign fifo_level      = reset ? '0 : fifo_lvl;
    assign issued_cnt      = reset ? '0 : issued_cnt_q;
    assign illegal_cmd     = !reset && illegal_q;
    assign frame_done      = !reset && (state_q == S_DONE);
    assign state_o         = state_q;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed bench for lcd_cmd_sched: a per-cycle vector table for the main
// issue/frame-close/illegal-code flow plus hand sequences for the busy hold,
// full FIFO, reset mid-frame and (with SCHED_TIMEOUT_EN) the watchdog.
module tb_lcd_cmd_sched;
    import lcd_pkg::*;

    localparam int TB_DEPTH   = 8;
    localparam int TB_CNT_W   = 8;
    localparam int TB_TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lcd_busy;
    logic       lcd_done;
    logic [3:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic [3:0] fifo_level;
    logic [7:0] issued_cnt;
    logic       illegal_cmd;
    logic       frame_done;
    logic       timeout;
    sched_state_t state_o;

    lcd_cmd_sched_if hif ();

    lcd_cmd_sched #(
        .DEPTH   (TB_DEPTH),
        .CNT_W   (TB_CNT_W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .host          (hif),
        .lcd_busy      (lcd_busy),
        .lcd_done      (lcd_done),
        .lcd_cmd       (lcd_cmd),
        .lcd_cmd_valid (lcd_cmd_valid),
        .fifo_level    (fifo_level),
        .issued_cnt    (issued_cnt),
        .illegal_cmd   (illegal_cmd),
        .frame_done    (frame_done),
        .timeout       (timeout),
        .state_o       (state_o)
    );

    // Clock: rising edges at 5, 15, 25 ...; inputs change on falling edges.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]   cmd;
        logic         valid;
        logic         busy;
        logic         done;
        logic         exp_ready;
        logic         exp_cvalid;
        logic [3:0]   exp_cmd;
        logic [3:0]   exp_level;
        logic [7:0]   exp_cnt;
        logic         exp_illegal;
        logic         exp_fdone;
        sched_state_t exp_state;
    } vec_t;

    vec_t vecs[$];
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [3:0] cmd, input logic valid,
                          input logic busy, input logic done);
        hif.host_cmd   = cmd;
        hif.host_valid = valid;
        lcd_busy       = busy;
        lcd_done       = done;
    endtask

    task automatic add_vec(input logic [3:0] cmd, input logic valid, input logic busy,
                           input logic done, input logic rdy, input logic cv,
                           input logic [3:0] lc, input logic [3:0] lvl, input logic [7:0] cnt,
                           input logic ill, input logic fd, input sched_state_t st);
        vec_t v;
        v.cmd = cmd; v.valid = valid; v.busy = busy; v.done = done;
        v.exp_ready = rdy; v.exp_cvalid = cv; v.exp_cmd = lc; v.exp_level = lvl;
        v.exp_cnt = cnt; v.exp_illegal = ill; v.exp_fdone = fd; v.exp_state = st;
        vecs.push_back(v);
    endtask

    // One reset cycle; outputs must read 0 while reset is high.
    task automatic do_reset(input logic busy);
        reset = 1'b1;
        set_in(4'd0, 1'b0, busy, 1'b0);
        #1;
        check("rst_ready",   32'(hif.host_ready), 32'd0);
        check("rst_cvalid",  32'(lcd_cmd_valid), 32'd0);
        check("rst_illegal", 32'(illegal_cmd), 32'd0);
        check("rst_fdone",   32'(frame_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [3:0] first_cmds [3];
        int strobes;
        int last_strobe;
        int n;

        first_cmds[0] = 4'd5;
        first_cmds[1] = 4'd7;
        first_cmds[2] = 4'd0;

        // Main flow table, starting in S_LOAD with 5,7,0 queued and busy high.
        //       cmd valid busy done | rdy cv lcmd lvl cnt ill fd state
        add_vec(4'd0,  0, 0, 0,   1, 0, 4'd0, 4'd3, 8'd0, 0, 0, S_LOAD);
        add_vec(4'd0,  0, 0, 0,   1, 1, 4'd5, 4'd3, 8'd0, 0, 0, S_IDLE);
        add_vec(4'd0,  0, 1, 0,   1, 0, 4'd5, 4'd2, 8'd1, 0, 0, S_GUARD);
        add_vec(4'd0,  0, 1, 0,   1, 0, 4'd5, 4'd2, 8'd1, 0, 0, S_WAIT);
        add_vec(4'd0,  0, 0, 0,   1, 0, 4'd5, 4'd2, 8'd1, 0, 0, S_WAIT);
        add_vec(4'd0,  0, 0, 0,   1, 1, 4'd7, 4'd2, 8'd1, 0, 0, S_IDLE);
        add_vec(4'd0,  0, 0, 0,   1, 0, 4'd7, 4'd1, 8'd2, 0, 0, S_GUARD);
        add_vec(4'd0,  0, 0, 0,   1, 0, 4'd7, 4'd1, 8'd2, 0, 0, S_WAIT);
        add_vec(4'd0,  0, 0, 0,   1, 1, 4'd0, 4'd1, 8'd2, 0, 0, S_IDLE);
        add_vec(4'd0,  0, 0, 0,   1, 0, 4'd0, 4'd0, 8'd3, 0, 0, S_FLUSH);
        add_vec(4'd9,  1, 0, 1,   1, 0, 4'd0, 4'd0, 8'd3, 0, 0, S_FLUSH);
        add_vec(4'd0,  0, 1, 0,   1, 0, 4'd0, 4'd1, 8'd3, 0, 1, S_DONE);
        add_vec(4'd0,  0, 1, 0,   1, 0, 4'd0, 4'd1, 8'd3, 0, 0, S_LOAD);
        add_vec(4'd0,  0, 1, 0,   1, 0, 4'd0, 4'd1, 8'd3, 0, 0, S_LOAD);
        add_vec(4'd0,  0, 0, 0,   1, 0, 4'd0, 4'd1, 8'd3, 0, 0, S_LOAD);
        add_vec(4'd0,  0, 0, 0,   1, 1, 4'd9, 4'd1, 8'd3, 0, 0, S_IDLE);
        add_vec(4'd0,  0, 0, 1,   1, 0, 4'd9, 4'd0, 8'd4, 0, 0, S_GUARD);
        add_vec(4'd0,  0, 0, 0,   1, 0, 4'd9, 4'd0, 8'd4, 0, 0, S_WAIT);
        add_vec(4'd0,  0, 0, 0,   1, 0, 4'd9, 4'd0, 8'd4, 0, 0, S_IDLE);
        add_vec(4'd13, 1, 0, 0,   1, 0, 4'd9, 4'd0, 8'd4, 0, 0, S_IDLE);
        add_vec(4'd4,  1, 0, 0,   1, 0, 4'd9, 4'd0, 8'd4, 1, 0, S_IDLE);
        add_vec(4'd0,  0, 0, 0,   1, 1, 4'd4, 4'd1, 8'd4, 1, 0, S_IDLE);
        add_vec(4'd0,  0, 0, 0,   1, 0, 4'd4, 4'd0, 8'd5, 1, 0, S_GUARD);
        add_vec(4'd0,  0, 0, 0,   1, 0, 4'd4, 4'd0, 8'd5, 1, 0, S_WAIT);

        // Reset block.
        set_in(4'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        do_reset(1'b1);

        // Ready gating: busy held for 70 cycles while 5,7,0 are queued.
        strobes = 0;
        for (int i = 0; i < 70; i++) begin
            if (i < 3) set_in(first_cmds[i], 1'b1, 1'b1, 1'b0);
            else       set_in(4'd0, 1'b0, 1'b1, 1'b0);
            #1;
            if (i == 0) begin
                check("post_rst_ready", 32'(hif.host_ready), 32'd1);
                check("post_rst_level", 32'(fifo_level), 32'd0);
                check("post_rst_cnt",   32'(issued_cnt), 32'd0);
                check("post_rst_state", 32'(state_o), 32'(S_LOAD));
                check("post_rst_cmd",   32'(lcd_cmd), 32'd0);
                check("post_rst_tmo",   32'(timeout), 32'd0);
            end
            if (lcd_cmd_valid) strobes++;
            @(negedge clk);
        end
        check("busy_hold_strobes", 32'(strobes), 32'd0);

        // Table-driven main flow.
        foreach (vecs[i]) begin
            set_in(vecs[i].cmd, vecs[i].valid, vecs[i].busy, vecs[i].done);
            #1;
            check($sformatf("v%0d_ready", i),   32'(hif.host_ready), 32'(vecs[i].exp_ready));
            check($sformatf("v%0d_cvalid", i),  32'(lcd_cmd_valid),  32'(vecs[i].exp_cvalid));
            check($sformatf("v%0d_lcd_cmd", i), 32'(lcd_cmd),        32'(vecs[i].exp_cmd));
            check($sformatf("v%0d_level", i),   32'(fifo_level),     32'(vecs[i].exp_level));
            check($sformatf("v%0d_cnt", i),     32'(issued_cnt),     32'(vecs[i].exp_cnt));
            check($sformatf("v%0d_illegal", i), 32'(illegal_cmd),    32'(vecs[i].exp_illegal));
            check($sformatf("v%0d_fdone", i),   32'(frame_done),     32'(vecs[i].exp_fdone));
            check($sformatf("v%0d_state", i),   32'(state_o),        32'(vecs[i].exp_state));
            @(negedge clk);
        end

        // Full FIFO: 9 pushes while busy, only 8 stored.
        do_reset(1'b1);
        for (int i = 0; i < 9; i++) begin
            set_in(4'(i + 1), 1'b1, 1'b1, 1'b0);
            #1;
            check($sformatf("full_ready%0d", i), 32'(hif.host_ready), (i < 8) ? 32'd1 : 32'd0);
            check($sformatf("full_level%0d", i), 32'(fifo_level), (i < 8) ? 32'(i) : 32'd8);
            if (i < 8) exp_q.push_back(4'(i + 1));
            @(negedge clk);
        end
        set_in(4'd0, 1'b0, 1'b1, 1'b0);
        #1;
        check("full_level_final", 32'(fifo_level), 32'd8);
        check("full_ready_final", 32'(hif.host_ready), 32'd0);
        @(negedge clk);

        // Release busy and drain, checking order and strobe spacing.
        last_strobe = -10;
        for (int c = 0; c < 60; c++) begin
            set_in(4'd0, 1'b0, 1'b0, 1'b0);
            #1;
            if (lcd_cmd_valid) begin
                check("drain_spacing_ok", 32'((c - last_strobe) >= 3), 32'd1);
                last_strobe = c;
                if (exp_q.size() == 0) check("drain_extra_issue", 32'(lcd_cmd), 32'hffff);
                else check("drain_cmd", 32'(lcd_cmd), 32'(exp_q.pop_front()));
            end
            @(negedge clk);
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        #1;
        check("drain_cnt",   32'(issued_cnt), 32'd8);
        check("drain_level", 32'(fifo_level), 32'd0);
        check("drain_ready", 32'(hif.host_ready), 32'd1);
        check("drain_state", 32'(state_o), 32'(S_IDLE));
        @(negedge clk);

        // Reset mid-frame with 3 queued in S_WAIT and illegal_cmd set.
        set_in(4'd1, 1'b1, 1'b0, 1'b0);  @(negedge clk);  // enqueue 1
        set_in(4'd0, 1'b0, 1'b0, 1'b0);  @(negedge clk);  // issue 1
        set_in(4'd2, 1'b1, 1'b1, 1'b0);  @(negedge clk);  // S_GUARD
        set_in(4'd3, 1'b1, 1'b1, 1'b0);  @(negedge clk);  // S_WAIT
        set_in(4'd15, 1'b1, 1'b1, 1'b0); @(negedge clk);  // dropped
        set_in(4'd4, 1'b1, 1'b1, 1'b0);  @(negedge clk);
        set_in(4'd0, 1'b0, 1'b1, 1'b0);
        #1;
        check("mid_state",   32'(state_o), 32'(S_WAIT));
        check("mid_level",   32'(fifo_level), 32'd3);
        check("mid_illegal", 32'(illegal_cmd), 32'd1);
        check("mid_cnt",     32'(issued_cnt), 32'd9);
        @(negedge clk);
        do_reset(1'b1);
        #1;
        check("mrst_level",   32'(fifo_level), 32'd0);
        check("mrst_cvalid",  32'(lcd_cmd_valid), 32'd0);
        check("mrst_cnt",     32'(issued_cnt), 32'd0);
        check("mrst_state",   32'(state_o), 32'(S_LOAD));
        check("mrst_illegal", 32'(illegal_cmd), 32'd0);
        check("mrst_lcd_cmd", 32'(lcd_cmd), 32'd0);
        @(negedge clk);

`ifdef SCHED_TIMEOUT_EN
        // Watchdog: issue 1, then hold busy until S_WAIT times out.
        set_in(4'd0, 1'b0, 1'b0, 1'b0); @(negedge clk);  // S_LOAD -> S_IDLE
        set_in(4'd1, 1'b1, 1'b0, 1'b0); @(negedge clk);  // enqueue
        set_in(4'd0, 1'b0, 1'b0, 1'b0); @(negedge clk);  // issue
        set_in(4'd0, 1'b0, 1'b1, 1'b0); @(negedge clk);  // S_GUARD
        n = 0;
        #1;
        while (state_o == S_WAIT && n < TB_TIMEOUT + 8) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("wd_wait_cycles", 32'(n), 32'(TB_TIMEOUT));
        check("wd_state",   32'(state_o), 32'(S_ERR));
        check("wd_timeout", 32'(timeout), 32'd1);
        check("wd_ready",   32'(hif.host_ready), 32'd0);
        @(negedge clk);
        set_in(4'd2, 1'b1, 1'b0, 1'b0); @(negedge clk);
        set_in(4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("wd_level_refused", 32'(fifo_level), 32'd0);
        check("wd_cnt",           32'(issued_cnt), 32'd1);
        check("wd_still_err",     32'(state_o), 32'(S_ERR));
        @(negedge clk);
`else
        n = 0;
        check("no_wd_timeout", 32'(timeout), 32'(n));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
